// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: FSM state encodings,
// stage indices and StallBus width helper.
package pipe_ctrl_pkg;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_MC_BUSY = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   // StallBus carries a PC-hold bit below the per-stage hold bits
   function automatic int stall_bus_w(input int num_stages);
      return num_stages + 1;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// Perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if #(
   parameter int NUM_STAGES = 5,
   parameter int LEN_W      = 6,
   parameter int SIDX_W     = 3
);
   logic [NUM_STAGES-1:0] stall_req;
   logic                  mc_start;
   logic [LEN_W-1:0]      mc_len;
   logic                  flush_req;
   logic [SIDX_W-1:0]     flush_stage;
   logic [31:0]           flush_pc;
   logic [NUM_STAGES:0]   stall;
   logic [NUM_STAGES-1:0] flush;
   logic                  redirect_valid;
   logic [31:0]           redirect_pc;
   logic                  mc_busy;
   logic                  mc_done;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]           perf_stall_cycles;
   logic [31:0]           perf_flush_cnt;
`endif

   modport master (
      output stall_req, mc_start, mc_len, flush_req, flush_stage, flush_pc,
      input  stall, flush, redirect_valid, redirect_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_PERF_EN
      , input perf_stall_cycles, perf_flush_cnt
`endif
   );

   modport slave (
      input  stall_req, mc_start, mc_len, flush_req, flush_stage, flush_pc,
      output stall, flush, redirect_valid, redirect_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_PERF_EN
      , output perf_stall_cycles, perf_flush_cnt
`endif
   );

endinterface

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Stall priority encoder: the highest requesting stage and everything
// upstream of it (including the PC) hold, as a thermometer mask.
module pipe_ctrl_stall_prio_enc #(
   parameter int W = 5
) (
   input  logic [W-1:0] req,
   output logic [W:0]   mask
);

   logic any_s;

   // Scan from the last stage down, accumulating "some later stage stalls"
   always_comb begin
      mask  = '0;
      any_s = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         any_s       = any_s | req[i];
         mask[i + 1] = any_s;
      end
      mask[0] = any_s;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall merge, multi-cycle op sequencing and
// registered flush/redirect. Optional perf counters via PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int MC_STAGE   = 2,
   parameter int LEN_W      = 6,
   parameter int SIDX_W     = 3
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);

   logic [1:0]            state_r, state_nxt_s;
   logic [LEN_W-1:0]      cnt_r, cnt_nxt_s;
   logic                  mc_accept_s;
   logic                  mc_hold_s;
   logic [NUM_STAGES-1:0] req_s;
   logic [NUM_STAGES:0]   mask_s;
   logic [NUM_STAGES-1:0] flush_mask_s;
   logic [NUM_STAGES-1:0] flush_r;
   logic                  redirect_valid_r;
   logic [31:0]           redirect_pc_r;

   // Multi-cycle acceptance and the merged per-stage request vector
   always_comb begin
      mc_accept_s = (state_r == ST_RUN) && bus.mc_start && !bus.flush_req
                    && (bus.mc_len >= LEN_W'(2));
      mc_hold_s   = mc_accept_s || ((state_r == ST_MC_BUSY) && (cnt_r > LEN_W'(1)));
      req_s       = bus.stall_req | (NUM_STAGES'(mc_hold_s) << MC_STAGE);
   end

   pipe_ctrl_stall_prio_enc #(.W(NUM_STAGES)) u_prio (
      .req  (req_s),
      .mask (mask_s)
   );

   // Stages 0..flush_stage; indices past the last stage saturate
   always_comb begin
      flush_mask_s = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         flush_mask_s[i] = (32'(bus.flush_stage) >= $unsigned(i));
      end
   end

   // Next-state logic; a flush request overrides everything and drops any op
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (bus.flush_req) begin
         state_nxt_s = ST_FLUSH;
         cnt_nxt_s   = '0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (mc_accept_s) begin
                  state_nxt_s = ST_MC_BUSY;
                  cnt_nxt_s   = bus.mc_len - LEN_W'(1);
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_MC_BUSY: begin
               if (cnt_r <= LEN_W'(1)) begin
                  state_nxt_s = ST_RUN;
                  cnt_nxt_s   = '0;
               end else begin
                  cnt_nxt_s = cnt_r - LEN_W'(1);
               end
            end
            ST_FLUSH: begin
               state_nxt_s = ST_RUN;
            end
            default: begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = '0;
            end
         endcase
      end
   end

   // State, counter and registered flush/redirect outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r          <= ST_RUN;
         cnt_r            <= '0;
         flush_r          <= '0;
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'h0000_0000;
      end else begin
         state_r          <= state_nxt_s;
         cnt_r            <= cnt_nxt_s;
         flush_r          <= bus.flush_req ? flush_mask_s : '0;
         redirect_valid_r <= bus.flush_req;
         if (bus.flush_req) begin
            redirect_pc_r <= bus.flush_pc;
         end
      end
   end

   // The flush cycle drains bubbles, so nothing holds during it
   assign bus.stall          = (rst && (state_r != ST_FLUSH)) ? mask_s : '0;
   assign bus.flush          = flush_r;
   assign bus.redirect_valid = redirect_valid_r;
   assign bus.redirect_pc    = redirect_pc_r;
   assign bus.mc_busy        = (state_r == ST_MC_BUSY);
   assign bus.mc_done        = (state_r == ST_MC_BUSY) && (cnt_r == LEN_W'(1));

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_r;
   logic [31:0] perf_flush_r;

   // Free-running wrap-around event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_r <= 32'h0000_0000;
         perf_flush_r <= 32'h0000_0000;
      end else begin
         if (bus.stall[0]) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end
         if (redirect_valid_r) begin
            perf_flush_r <= perf_flush_r + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cycles = perf_stall_r;
   assign bus.perf_flush_cnt    = perf_flush_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model pushes
// expected outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;

   localparam int NS = 5;
   localparam int MC = 2;

   typedef struct packed {
      logic [NS:0]   stall;
      logic [NS-1:0] flush;
      logic          rv;
      logic [31:0]   pc;
      logic          busy;
      logic          done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.NUM_STAGES(NS), .LEN_W(6), .SIDX_W(3)) bus ();

   pipe_ctrl #(.NUM_STAGES(NS), .MC_STAGE(MC), .LEN_W(6), .SIDX_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model state: absolute cycle numbers, not counters
   int          cyc         = 0;
   int          mc_start_at = -1;
   int          mc_done_at  = -1;
   bit          flush_pend  = 1'b0;
   int          pend_stage  = 0;
   logic [31:0] last_pc     = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
      end
   endtask

   task automatic drive(input logic r, input logic [4:0] sr, input logic ms,
                        input logic [5:0] ml, input logic fr, input logic [2:0] fs,
                        input logic [31:0] fp);
      exp_t e;
      int   h;
      bit   busy, infl, acc, mcst;
      @(posedge clk);
      #1;
      rst             = r;
      bus.stall_req   = sr;
      bus.mc_start    = ms;
      bus.mc_len      = ml;
      bus.flush_req   = fr;
      bus.flush_stage = fs;
      bus.flush_pc    = fp;
      e = '0;
      if (!r) begin
         mc_start_at = -1;
         mc_done_at  = -1;
         flush_pend  = 1'b0;
         last_pc     = 32'h0;
      end else begin
         infl = flush_pend;
         busy = (mc_done_at >= 0) && (cyc > mc_start_at) && (cyc <= mc_done_at);
         acc  = !infl && !busy && ms && !fr && (ml >= 6'd2);
         mcst = acc || (busy && (cyc < mc_done_at));
         h = -1;
         for (int i = 0; i < NS; i++) if (sr[i]) h = i;
         if (mcst && h < MC) h = MC;
         e.stall = (infl || h < 0) ? '0 : 6'((1 << (h + 2)) - 1);
         e.busy  = busy;
         e.done  = busy && (cyc == mc_done_at);
         e.rv    = infl;
         e.flush = infl ? 5'((1 << ((pend_stage >= NS) ? NS : pend_stage + 1)) - 1) : '0;
         e.pc    = last_pc;
         if (fr) begin
            mc_done_at = -1;
            flush_pend = 1'b1;
            pend_stage = int'(fs);
            last_pc    = fp;
         end else begin
            flush_pend = 1'b0;
         end
         if (acc) begin
            mc_start_at = cyc;
            mc_done_at  = cyc + int'(ml) - 1;
         end
      end
      q.push_back(e);
      cyc++;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) drive(1'b1, 5'd0, 1'b0, 6'd0, 1'b0, 3'd0, 32'h0);
   endtask

   // Monitor: outputs are presented every cycle, compare on the falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("stall",          32'(bus.stall),          32'(e.stall));
         chk("flush",          32'(bus.flush),          32'(e.flush));
         chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
         chk("redirect_pc",    bus.redirect_pc,         e.pc);
         chk("mc_busy",        32'(bus.mc_busy),        32'(e.busy));
         chk("mc_done",        32'(bus.mc_done),        32'(e.done));
      end
   end

   initial begin
      bus.stall_req   = '0;
      bus.mc_start    = 1'b0;
      bus.mc_len      = '0;
      bus.flush_req   = 1'b0;
      bus.flush_stage = '0;
      bus.flush_pc    = '0;
      drive(1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 3'd0, 32'h0);
      drive(1'b0, 5'b11111, 1'b1, 6'd4, 1'b1, 3'd4, 32'h1234);
      idle(2);
      // ID load-use stall, then release
      drive(1'b1, 5'b00010, 1'b0, 6'd0, 1'b0, 3'd0, 32'h0);
      idle(2);
      // 4-cycle multi-cycle op
      drive(1'b1, 5'd0, 1'b1, 6'd4, 1'b0, 3'd0, 32'h0);
      idle(5);
      // flush stages 0..1
      drive(1'b1, 5'd0, 1'b0, 6'd0, 1'b1, 3'd1, 32'hBFC0_0380);
      idle(3);
      // flush one cycle into a 6-cycle op
      drive(1'b1, 5'd0, 1'b1, 6'd6, 1'b0, 3'd0, 32'h0);
      drive(1'b1, 5'd0, 1'b0, 6'd0, 1'b1, 3'd2, 32'hABCD_0000);
      idle(8);
      // back-to-back flushes, second saturating
      drive(1'b1, 5'd0, 1'b0, 6'd0, 1'b1, 3'd0, 32'h0000_0100);
      drive(1'b1, 5'd0, 1'b0, 6'd0, 1'b1, 3'd7, 32'h0000_0200);
      idle(3);
      // single-cycle lengths are ignored; mc_start while busy is ignored
      drive(1'b1, 5'd0, 1'b1, 6'd1, 1'b0, 3'd0, 32'h0);
      drive(1'b1, 5'd0, 1'b1, 6'd3, 1'b0, 3'd0, 32'h0);
      drive(1'b1, 5'b10000, 1'b1, 6'd9, 1'b0, 3'd0, 32'h0);
      idle(4);
      // reset mid-op (cnt=5), with all stall requests high
      drive(1'b1, 5'd0, 1'b1, 6'd7, 1'b0, 3'd0, 32'h0);
      idle(1);
      drive(1'b0, 5'b11111, 1'b0, 6'd0, 1'b0, 3'd0, 32'h0);
      drive(1'b0, 5'b11111, 1'b0, 6'd0, 1'b0, 3'd0, 32'h0);
      idle(3);
      for (int i = 0; i < 600; i++) begin
         drive(1'b1,
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
               ($urandom_range(0, 5) == 0),
               6'($urandom_range(0, 12)),
               ($urandom_range(0, 14) == 0),
               3'($urandom),
               $urandom);
      end
      idle(1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
